rtc_readout_sequencer: RTL

Schedules one burst of RTC register reads per video frame, during vertical blanking. The burst walks a fixed table of RTC register addresses, using a req/ack handshake toward the RTC bus controller. Each returned BCD byte is converted to binary and presented as a one-cycle data strobe to the display capture logic. The capture logic then stores the values into its per-field ASCII registers before the next visible frame.

---
 rtl/rtc_readout_sequencer_if.sv | 18 +
 rtl/rtc_readout_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/rtc_readout_sequencer_if.sv
// RTC bus controller read channel: req/addr toward the controller,
// one-cycle ack with data back.
interface rtc_readout_sequencer_if;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_ack;
  logic [7:0] rd_data;

  modport master (
    output rd_req, rd_addr,
    input  rd_ack, rd_data
  );

  modport slave (
    input  rd_req, rd_addr,
    output rd_ack, rd_data
  );
endinterface

// File: rtl/rtc_readout_sequencer.sv
// One RTC register burst per frame in vblank, BCD -> binary strobes.
// Define RTC_SEQ_TIMEOUT_EN to abort a request left unacked TIMEOUT cycles.
module rtc_readout_sequencer #(
  parameter int NUM_REGS    = 11,
  parameter int VBLANK_LINE = 480,
  parameter int TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixely,
  rtc_readout_sequencer_if.master rtc,
  output logic [7:0] dato_out,
  output logic       dato_valid,
  output logic [3:0] field_idx,
  output logic       frame_done,
  output logic       busy,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, CONV, EMIT, DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(NUM_REGS - 1);

  state_t     state, stateNext;
  logic [3:0] idx, idxNext;
  logic [7:0] rdAddr, dataQ;
  logic       vb, vbQ, trig, fall;
  logic       abortQ, loadAddr;
  logic [3:0] hi, lo;
  logic       bcdOk;
  logic [7:0] binVal;

  assign vb   = pixely >= 10'(VBLANK_LINE);
  assign trig = vb & ~vbQ;
  assign fall = ~vb & vbQ;

  assign hi     = dataQ[7:4];
  assign lo     = dataQ[3:0];
  assign bcdOk  = (hi <= 4'd9) && (lo <= 4'd9);
  assign binVal = {1'b0, hi, 3'b000}
                + {3'b000, hi, 1'b0}
                + {4'b0000, lo};

  assign rtc.rd_req  = (state == REQ) || (state == WAIT);
  assign rtc.rd_addr = rdAddr;
  assign dato_valid  = state == EMIT;
  assign frame_done  = state == DONE;
  assign busy        = (state != IDLE) && (state != DONE);

  function automatic logic [7:0] addrOf(input logic [3:0] i);
    case (i)
      4'd0:    addrOf = 8'h21;
      4'd1:    addrOf = 8'h22;
      4'd2:    addrOf = 8'h23;
      4'd3:    addrOf = 8'h24;
      4'd4:    addrOf = 8'h25;
      4'd5:    addrOf = 8'h26;
      4'd6:    addrOf = 8'h27;
      4'd7:    addrOf = 8'h28;
      4'd8:    addrOf = 8'h41;
      4'd9:    addrOf = 8'h42;
      4'd10:   addrOf = 8'h43;
      default: addrOf = 8'h00;
    endcase
  endfunction

`ifdef RTC_SEQ_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] waitCnt;
  logic       toHit;
  assign toHit = (state == WAIT) && !rtc.rd_ack
              && (waitCnt == TO_LAST);
`else
  logic unusedTimeout;
  assign unusedTimeout = TIMEOUT[0];
`endif

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    loadAddr  = 1'b0;
    unique case (state)
      IDLE: if (trig) begin
        stateNext = REQ;
        idxNext   = 4'd0;
        loadAddr  = 1'b1;
      end
      REQ: stateNext = WAIT;
      WAIT: begin
        if (rtc.rd_ack) stateNext = CONV;
`ifdef RTC_SEQ_TIMEOUT_EN
        else if (toHit) stateNext = IDLE;
`endif
      end
      CONV: stateNext = EMIT;
      // a blank that ended anywhere in the burst stops it after this field
      EMIT: begin
        if (abortQ || fall) stateNext = IDLE;
        else if (idx == LAST) stateNext = DONE;
        else begin
          stateNext = REQ;
          idxNext   = idx + 4'd1;
          loadAddr  = 1'b1;
        end
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 4'd0;
      vbQ       <= 1'b0;
      abortQ    <= 1'b0;
      rdAddr    <= 8'h00;
      dataQ     <= 8'h00;
      dato_out  <= 8'h00;
      field_idx <= 4'd0;
      error     <= 1'b0;
`ifdef RTC_SEQ_TIMEOUT_EN
      waitCnt   <= 8'd0;
`endif
    end else begin
      state  <= stateNext;
      idx    <= idxNext;
      vbQ    <= vb;
      abortQ <= (state == IDLE) ? 1'b0 : (abortQ | fall);
      if (loadAddr) rdAddr <= addrOf(idxNext);
      if (state == WAIT && rtc.rd_ack) dataQ <= rtc.rd_data;
      if (state == CONV) begin
        dato_out  <= bcdOk ? binVal : 8'hFF;
        field_idx <= idx;
        if (!bcdOk) error <= 1'b1;
      end
`ifdef RTC_SEQ_TIMEOUT_EN
      if (state == REQ) waitCnt <= 8'd0;
      else if (state == WAIT) waitCnt <= waitCnt + 8'd1;
      if (toHit) error <= 1'b1;
`endif
    end
  end

endmodule
